demux_stream_1xn: RTL
=====================

Name: demux_stream_1xn

Overview:
- Parametrised successor to the combinational 1x16 demultiplexer: routes a W-bit data stream from one source to one of N output channels, with a valid/ready handshake on each side.
- Each channel has a one-entry registered output slot, so downstream back-pressure is isolated per channel.
- Adds a broadcast mode, out-of-range select detection and a saturating drop counter.
- Sits between a single producer and N independent consumers in datapath test structures.

Parameters:
- N, 16, number of output channels (2..64).
- W, 8, data width in bits.
- SW, 4, select width; must satisfy 2^SW >= N.
- CW, 8, drop-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source has a beat.
- in_ready  output  1  beat accepted when in_valid and in_ready are both high.
- in_data  input  W  payload.
- in_sel  input  SW  target channel index.
- in_bcast  input  1  1 = deliver the beat to all N channels; in_sel is ignored.
- out_valid  output  N  bit k: channel k slot is full.
- out_ready  input  N  bit k: consumer k takes the beat.
- out_data  output  N*W  channel k occupies bits [k*W+W-1 : k*W].
- err_sel  output  1  one-cycle pulse when a beat with in_sel >= N is accepted (non-broadcast).
- drop_cnt  output  CW  saturating count of dropped beats.

Behaviour:
- Reset (async, asserted immediately): out_valid=0, out_data=0, err_sel=0, drop_cnt=0. in_ready is combinational and therefore reads 0 while rst=1.
- Slot k:
  - "free" = !out_valid[k] or out_ready[k] (drain and refill allowed in the same cycle).
  - A channel k beat completes when out_valid[k] and out_ready[k] are both high.
- in_ready, combinational:
  - unicast with in_sel < N: free[in_sel].
  - broadcast: AND of free[0..N-1].
  - in_sel >= N: 1 (the beat is always sunk).
- Accepted unicast beat: slot[in_sel] loads in_data and out_valid[in_sel] rises on the next edge. Latency is 1 cycle.
- Accepted broadcast beat: all N slots load in_data together. Delivery is all-or-nothing; there are no partial broadcasts.
- Accepted beat with in_sel >= N (non-broadcast):
  - data discarded, no slot changes;
  - err_sel = 1 for exactly the next cycle;
  - drop_cnt increments and saturates at 2^CW-1 (no wrap).
- Slot k completing with no new load: out_valid[k] clears on the next edge. out_data[k] holds its last value, so data is don't-care when valid is low.
- Slot k completing and reloading in the same cycle: out_valid[k] stays 1 and the new data appears on the next edge. Back-to-back throughput is one beat per cycle per channel.
- Stall: while out_valid[k]=1 and out_ready[k]=0, out_data[k] is stable.
- Source rules: the source must hold in_data, in_sel and in_bcast stable while in_valid=1 and in_ready=0. in_ready must not depend on in_valid (no combinational loop).
- Reset asserted mid-transfer: all slots empty immediately and drop_cnt=0. Beats in flight are lost and are not counted as drops.
- No FSM beyond the per-slot full/empty bit. Only the slot register and drop_cnt are stateful.

Decomposition:
- Shared constants header demux_defs.vh holds:
  - default N/W/SW/CW;
  - the localparam DROP_MAX = {CW{1'b1}};
  - a compile-time check macro for 2^SW >= N.
- One sub-module, demux_slot: a one-entry register with load/drain, parameter W, ports clk, rst, ld, d, rdy, vld, q.
- Instantiate demux_slot N times with a generate loop. Select decode and broadcast logic stay in the top level.

Test Plan:
- Reset, then sweep all 16 selects with out_ready=all 1s: in_sel=k, in_data=8'hA0+k gives out_valid[k]=1 one cycle later with data A0+k; in_ready stays 1 throughout.
- Back-pressure on channel 3: out_ready[3]=0, send two beats to ch3 (11, 22).
  - Expected: first held in the slot, in_ready=0 on the second.
  - Release out_ready[3]: 11 then 22 appear on consecutive cycles.
  - Other channels are unaffected.
- Broadcast blocked: ch5 full and stalled, in_bcast=1, data=5A.
  - Expected: in_ready=0 and no slot loads.
  - Release ch5: all 16 slots show 5A on the same cycle.
- Out-of-range select with N=12, SW=4: in_sel=13 gives in_ready=1, a one-cycle err_sel pulse, drop_cnt=1 and no out_valid change.
- Saturation with CW=2: send 5 out-of-range beats; drop_cnt reads 1, 2, 3, 3, 3.
- Async reset mid-stream: assert rst between edges with 4 full slots.
  - Expected: out_valid=0 and drop_cnt=0 before the next edge.
  - After release, the first new beat routes normally.

Source files
------------

// File: rtl/demux_stream_1xn_pkg.sv
// Shared defaults, beat classification and elaboration helpers for the
// 1xN stream demultiplexer.
package demux_stream_1xn_pkg;

  // Default geometry: 16 channels of 8-bit data, 4-bit select, 8-bit drop counter.
  localparam int DEF_N  = 16;
  localparam int DEF_W  = 8;
  localparam int DEF_SW = 4;
  localparam int DEF_CW = 8;

  // What happens to the beat presented this cycle.
  typedef enum logic [1:0] {
    ROUTE_NONE  = 2'd0,  // nothing accepted
    ROUTE_UNI   = 2'd1,  // accepted into one slot
    ROUTE_BCAST = 2'd2,  // accepted into every slot at once
    ROUTE_DROP  = 2'd3   // accepted but the select names no channel
  } route_e;

  // True when an SW-bit select can address all n channels.
  function automatic bit sel_width_ok(input int n, input int sw);
    return ((64'd1 << sw) >= 64'(n));
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single channel. A load always wins; a
// completed transfer with no load empties the slot. Data is held while empty.
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         rdy,
  output logic         vld,
  output logic [W-1:0] q
);

  logic         r_vld;
  logic [W-1:0] r_q;

  // Slot occupancy and payload: load, drain, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_q   <= {W{1'b0}};
    end else if (ld) begin
      r_vld <= 1'b1;
      r_q   <= d;
    end else if (r_vld && rdy) begin
      r_vld <= 1'b0;
      r_q   <= r_q;
    end else begin
      r_vld <= r_vld;
      r_q   <= r_q;
    end
  end

  assign vld = r_vld;
  assign q   = r_q;

endmodule

// File: rtl/demux_stream_1xn.sv
// 1xN valid/ready stream demultiplexer with per-channel output slots,
// all-or-nothing broadcast, out-of-range select sinking and a saturating
// drop counter.
module demux_stream_1xn
  import demux_stream_1xn_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int SW = DEF_SW,
  parameter int CW = DEF_CW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_bcast,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [N*W-1:0] out_data,
  output logic           err_sel,
  output logic [CW-1:0]  drop_cnt
);

  localparam logic [CW-1:0] DROP_MAX = {CW{1'b1}};
  localparam logic [SW:0]   N_L      = (SW+1)'(N);

  // The select must be wide enough to name every channel.
  if (!sel_width_ok(N, SW)) begin : g_sel_width_check
    $error("demux_stream_1xn: 2**SW must be >= N");
  end

  logic [N-1:0]        w_sel_oh;
  logic [N-1:0]        w_free;
  logic [N-1:0]        w_slot_vld;
  logic [N-1:0][W-1:0] w_slot_q;
  logic [N-1:0]        w_ld;
  logic                w_in_range;
  logic                w_in_ready;
  route_e              w_route;
  logic                r_err_sel;
  logic [CW-1:0]       r_drop_cnt;

  assign w_in_range = ({1'b0, in_sel} < N_L);

  // Per-channel select decode; a slot is free when empty or draining now.
  for (genvar k = 0; k < N; k++) begin : g_dec
    assign w_sel_oh[k] = (in_sel == SW'(k));
    assign w_free[k]   = !w_slot_vld[k] || out_ready[k];
  end

  // Source-side ready: depends only on slot state, select and mode, never on in_valid.
  always_comb begin
    w_in_ready = 1'b0;
    if (rst) begin
      w_in_ready = 1'b0;
    end else if (in_bcast) begin
      w_in_ready = &w_free;
    end else if (!w_in_range) begin
      w_in_ready = 1'b1;
    end else begin
      w_in_ready = |(w_sel_oh & w_free);
    end
  end

  // Classify the beat accepted this cycle.
  always_comb begin
    w_route = ROUTE_NONE;
    if (in_valid && w_in_ready) begin
      if (in_bcast) begin
        w_route = ROUTE_BCAST;
      end else if (w_in_range) begin
        w_route = ROUTE_UNI;
      end else begin
        w_route = ROUTE_DROP;
      end
    end else begin
      w_route = ROUTE_NONE;
    end
  end

  // Slot load enables derived from the beat classification.
  always_comb begin
    w_ld = {N{1'b0}};
    case (w_route)
      ROUTE_UNI:   w_ld = w_sel_oh;
      ROUTE_BCAST: w_ld = {N{1'b1}};
      ROUTE_DROP:  w_ld = {N{1'b0}};
      ROUTE_NONE:  w_ld = {N{1'b0}};
      default:     w_ld = {N{1'b0}};
    endcase
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(
      .W (W)
    ) u_slot (
      .clk (clk),
      .rst (rst),
      .ld  (w_ld[k]),
      .d   (in_data),
      .rdy (out_ready[k]),
      .vld (w_slot_vld[k]),
      .q   (w_slot_q[k])
    );
  end

  // Error pulse for one cycle after a sunk beat; drop counter sticks at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sel  <= 1'b0;
      r_drop_cnt <= {CW{1'b0}};
    end else begin
      r_err_sel <= (w_route == ROUTE_DROP);
      if ((w_route == ROUTE_DROP) && (r_drop_cnt != DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + CW'(1);
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_slot_vld;
  assign out_data  = w_slot_q;
  assign err_sel   = r_err_sel;
  assign drop_cnt  = r_drop_cnt;

endmodule
